// File: rtl/cond_logic_multi.sv
// rtl/cond_logic_multi.sv - conditional-execution stage: NZCV flags, condition check, write-enable gating
module cond_logic_multi #(
    parameter int FLAG_W       = 4,
    parameter bit COND_NV_EXEC = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              Rd15,
    input  logic              NextPC,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              Branch,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [FLAG_W-1:0] Flags,
    output logic              CondExQ
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_cond_ex_q;
    logic              w_cond_ex;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic [1:0]        w_flag_write;
    logic              w_pcs;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluate the instruction condition against the pre-update flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'h0:    w_cond_ex = w_z;
            4'h1:    w_cond_ex = ~w_z;
            4'h2:    w_cond_ex = w_c;
            4'h3:    w_cond_ex = ~w_c;
            4'h4:    w_cond_ex = w_n;
            4'h5:    w_cond_ex = ~w_n;
            4'h6:    w_cond_ex = w_v;
            4'h7:    w_cond_ex = ~w_v;
            4'h8:    w_cond_ex = w_c & ~w_z;
            4'h9:    w_cond_ex = ~w_c | w_z;
            4'hA:    w_cond_ex = (w_n == w_v);
            4'hB:    w_cond_ex = (w_n != w_v);
            4'hC:    w_cond_ex = ~w_z & (w_n == w_v);
            4'hD:    w_cond_ex = w_z | (w_n != w_v);
            4'hE:    w_cond_ex = 1'b1;
            default: w_cond_ex = COND_NV_EXEC;
        endcase
    end

    // Flag groups are written only when this instruction's condition passes
    assign w_flag_write = FlagW & {2{w_cond_ex}};

    // Flag registers and the one-cycle-delayed condition result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= '0;
            r_cond_ex_q <= 1'b0;
        end else begin
            r_cond_ex_q <= w_cond_ex;
            if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // A write to R15 is a PC update just like a branch
    assign w_pcs = Branch | (Rd15 & RegW);

    // Architectural enables; fetch (NextPC) always advances regardless of condition
    always_comb begin
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        if (!reset) begin
            PCWrite  = NextPC | (w_pcs & r_cond_ex_q);
            RegWrite = RegW & r_cond_ex_q;
            MemWrite = MemW & r_cond_ex_q;
        end
    end

    assign Flags   = r_flags;
    assign CondExQ = r_cond_ex_q;

endmodule

// File: tb/tb_cond_logic_multi.sv
// tb/tb_cond_logic_multi.sv - self-checking bench for cond_logic_multi
module tb_cond_logic_multi;

    localparam bit NV = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       Rd15, NextPC, RegW, MemW, Branch;
    logic       PCWrite, RegWrite, MemWrite, CondExQ;
    logic [3:0] Flags;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    cond_logic_multi #(.FLAG_W(4), .COND_NV_EXEC(NV)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .Rd15(Rd15), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondExQ(CondExQ)
    );

    always #5 clk = ~clk;

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return NV;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs);
        logic [3:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    initial begin
        reset = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
        Rd15 = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; Branch = 1'b1;
        @(negedge clk);
        tick();
        tick();
        push(4'h0); chk("rst_pcwrite", {3'b0, PCWrite});
        push(4'h0); chk("rst_regwrite", {3'b0, RegWrite});
        push(4'h0); chk("rst_memwrite", {3'b0, MemWrite});
        push(4'h0); chk("rst_flags", Flags);
        push(4'h0); chk("rst_condexq", {3'b0, CondExQ});

        // Release: first decode with AL sets CondExQ one cycle later
        reset = 1'b0; FlagW = 2'b00; ALUFlags = 4'h0;
        NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; Branch = 1'b0;
        #1;
        push(4'h0); chk("post_rst_regwrite_suppressed", {3'b0, RegWrite});
        tick();
        push(4'h1); chk("al_condexq", {3'b0, CondExQ});

        // EQ with Z=1 passes, NE fails
        load_flags(4'b0100);
        push(4'b0100); chk("flags_z", Flags);
        Cond = 4'h0; tick();
        Cond = 4'hE; RegW = 1'b1; MemW = 1'b1; #1;
        push(4'h1); chk("eq_regwrite", {3'b0, RegWrite});
        push(4'h1); chk("eq_memwrite", {3'b0, MemWrite});
        RegW = 1'b0; MemW = 1'b0;
        Cond = 4'h1; tick();
        RegW = 1'b1; MemW = 1'b1; #1;
        push(4'h0); chk("ne_regwrite", {3'b0, RegWrite});
        push(4'h0); chk("ne_memwrite", {3'b0, MemWrite});
        RegW = 1'b0; MemW = 1'b0;

        // Independent flag groups
        load_flags(4'b0000);
        Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1011; tick();
        push(4'b1000); chk("flagw_nz", Flags);
        FlagW = 2'b01; ALUFlags = 4'b0111; tick();
        push(4'b1011); chk("flagw_cv", Flags);
        FlagW = 2'b00;

        // Failing condition suppresses the flag write
        load_flags(4'b0000);
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'hF; tick();
        FlagW = 2'b00;
        push(4'b0000); chk("flagw_suppressed", Flags);
        push(4'h0); chk("eq_false_condexq", {3'b0, CondExQ});

        // PC gating with CondExQ=0
        Branch = 1'b1; #1;
        push(4'h0); chk("branch_gated", {3'b0, PCWrite});
        Branch = 1'b0; NextPC = 1'b1; #1;
        push(4'h1); chk("nextpc_ungated", {3'b0, PCWrite});
        NextPC = 1'b0;
        Cond = 4'hE; tick();
        Rd15 = 1'b1; RegW = 1'b1; #1;
        push(4'h1); chk("rd15_pcwrite", {3'b0, PCWrite});
        push(4'h1); chk("rd15_regwrite", {3'b0, RegWrite});
        Rd15 = 1'b0; RegW = 1'b0;

        // Condition uses pre-update flags when written in the same cycle
        load_flags(4'b0100);
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0000; tick();
        FlagW = 2'b00;
        push(4'h1); chk("preupdate_condexq", {3'b0, CondExQ});
        push(4'b0000); chk("preupdate_flags", Flags);

        // Reset mid-instruction clears the pending qualification
        Cond = 4'hE; tick();
        reset = 1'b1; tick();
        reset = 1'b0; RegW = 1'b1; MemW = 1'b1; Branch = 1'b1; #1;
        push(4'h0); chk("midrst_regwrite", {3'b0, RegWrite});
        push(4'h0); chk("midrst_memwrite", {3'b0, MemWrite});
        push(4'h0); chk("midrst_pcwrite", {3'b0, PCWrite});
        RegW = 1'b0; MemW = 1'b0; Branch = 1'b0;

        // Full condition table sweep
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(f[3:0]);
                Cond = c[3:0]; tick();
                push({3'b0, cond_model(c[3:0], f[3:0])});
                chk($sformatf("sweep_c%0h_f%0h", c, f), {3'b0, CondExQ});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_logic_multi.md
Name: cond_logic_multi

Overview:
- Conditional-execution stage directly downstream of the microcoded control sequencer in the multicycle core.
- Holds the NZCV flag registers and evaluates the 4-bit instruction condition field against them.
- Registers the condition result across the instruction's cycles.
- Gates the sequencer's raw write strobes (NextPC, RegW, MemW, Branch) into the architectural enables PCWrite, RegWrite and MemWrite that drive the PC, register file and data memory.

Parameters:
- FLAG_W, 4, flag register width (N,Z,C,V in bits [3:0]); fixed at 4, present for documentation only.
- COND_NV_EXEC, 0, execute result for Cond=4'b1111 (0 = never, 1 = always).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  condition field Instr[31:28] from instruction register.
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
- FlagW  input  2  flag-write request from ALU decoder; [1]=N,Z group, [0]=C,V group.
- Rd15  input  1  destination register is R15 (Instr[15:12]==4'hF).
- NextPC  input  1  unconditional PC update strobe from sequencer (fetch cycle).
- RegW  input  1  raw register-write strobe from sequencer.
- MemW  input  1  raw memory-write strobe from sequencer.
- Branch  input  1  branch strobe from sequencer.
- PCWrite  output  1  PC register enable.
- RegWrite  output  1  register-file write enable.
- MemWrite  output  1  data-memory write enable.
- Flags  output  4  current registered {N,Z,C,V}.
- CondExQ  output  1  registered condition result (debug/verification visibility).

Behaviour:
- Reset: synchronous, active-high. On a clk edge with reset=1, Flags<=4'b0000 and CondExQ<=0. While reset=1, PCWrite, RegWrite and MemWrite are forced to 0 regardless of inputs.
- Condition evaluation (combinational CondEx from registered Flags and Cond):
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C. 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V. C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: COND_NV_EXEC.
- CondExQ <= CondEx on every rising edge when reset=0. This gives a 1-cycle delay: the value evaluated in the decode cycle qualifies the execute, memory and writeback cycles.
- Flag update uses the current (undelayed) CondEx:
  - FlagWrite[1] = FlagW[1] & CondEx; on the edge, Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondEx; on the edge, Flags[1:0] <= ALUFlags[1:0].
  - The two groups update independently. Unselected bits hold.
- PCS = Branch | (Rd15 & RegW).
- Output gating (combinational, reset=0):
  - PCWrite = NextPC | (PCS & CondExQ).
  - RegWrite = RegW & CondExQ.
  - MemWrite = MemW & CondExQ.
- NextPC is never gated; fetch always advances the PC.
- Simultaneous flag write and a condition depending on those flags: CondEx uses the pre-update Flags. The new flags are visible from the next cycle.
- Reset mid-instruction: CondExQ clears, so any pending RegW/MemW/Branch in the cycle after reset deassertion is suppressed until a new decode cycle has been evaluated.
- No X-propagation tolerance is required on Cond during reset. After reset, all state is defined.

Test Plan:
- Reset with reset=1 for 2 cycles, RegW=MemW=NextPC=1 -> PCWrite=RegWrite=MemWrite=0, Flags=0000, CondExQ=0; after release with Cond=E, CondExQ=1 one cycle later.
- Flags=0100 (Z=1), Cond=0 (EQ) in decode, next cycle RegW=1, MemW=1 -> RegWrite=1, MemWrite=1; repeat with Cond=1 (NE) -> both 0.
- Cond=E, FlagW=2'b10, ALUFlags=1011 -> Flags becomes 1000 (N,Z updated to 10; C,V held at 00); then FlagW=2'b01, ALUFlags=0111 -> Flags=1011.
- Flags=0000, Cond=0 (EQ false), FlagW=2'b11, ALUFlags=1111 -> Flags stays 0000 (flag write suppressed).
- Branch=1 with CondExQ=0 -> PCWrite=0; NextPC=1 with CondExQ=0 -> PCWrite=1; Rd15=1, RegW=1, CondExQ=1 -> PCWrite=1 and RegWrite=1.
- Sweep all 16 Cond values over all 16 Flags values -> CondExQ matches the condition table one cycle later (256 checks; Cond=F gives COND_NV_EXEC).
